// File: rtl/udl_mod_counter.sv
// udl_mod_counter: modulo-MOD up/down counter with clamped parallel load, terminal count and wrap pulse.
// Optional registered compare output (cmp/match) is built only when UDL_MATCH_EN is defined.
module udl_mod_counter #(
  parameter int BITS     = 4,
  parameter int MOD      = 10,
  parameter int SATURATE = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            enable,
  input  logic            clr,
  input  logic            up,
  input  logic            load,
  input  logic [BITS-1:0] D,
`ifdef UDL_MATCH_EN
  input  logic [BITS-1:0] cmp,
  output logic            match,
`endif
  output logic [BITS-1:0] Q,
  output logic            tc,
  output logic            wrap_pulse
);

  localparam logic [BITS-1:0] MAX_C  = BITS'(MOD - 1);
  localparam logic [BITS-1:0] ZERO_C = {BITS{1'b0}};
  localparam logic [BITS-1:0] ONE_C  = BITS'(1);

  logic [BITS-1:0] q_r;
  logic [BITS-1:0] q_next_s;
  logic [BITS-1:0] d_clamp_s;
  logic            wrap_r;
  logic            count_s;
  logic            tc_s;
  logic            wrap_s;

  // Terminal count, load clamp and wrap detection from current inputs and count
  always_comb begin
    count_s = enable & ~clr & ~load;
    if (up) begin
      tc_s = count_s & (q_r == MAX_C);
    end else begin
      tc_s = count_s & (q_r == ZERO_C);
    end
    if (D > MAX_C) begin
      d_clamp_s = MAX_C;
    end else begin
      d_clamp_s = D;
    end
    if (SATURATE != 0) begin
      wrap_s = 1'b0;
    end else begin
      wrap_s = tc_s;
    end
  end

  // Next-count selection: clr > load > count > hold; out-of-range counts recover as terminal
  always_comb begin
    q_next_s = q_r;
    if (clr) begin
      q_next_s = ZERO_C;
    end else if (enable && load) begin
      q_next_s = d_clamp_s;
    end else if (enable) begin
      if (up) begin
        if (q_r == MAX_C) begin
          q_next_s = (SATURATE != 0) ? MAX_C : ZERO_C;
        end else if (q_r > MAX_C) begin
          q_next_s = ZERO_C;
        end else begin
          q_next_s = q_r + ONE_C;
        end
      end else begin
        if (q_r == ZERO_C) begin
          q_next_s = (SATURATE != 0) ? ZERO_C : MAX_C;
        end else if (q_r > MAX_C) begin
          q_next_s = MAX_C;
        end else begin
          q_next_s = q_r - ONE_C;
        end
      end
    end else begin
      q_next_s = q_r;
    end
  end

  // Count and wrap pulse registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_r    <= ZERO_C;
      wrap_r <= 1'b0;
    end else begin
      q_r    <= q_next_s;
      wrap_r <= wrap_s;
    end
  end

`ifdef UDL_MATCH_EN
  logic match_r;

  // Compare against the next count so match lines up with the cycle Q equals cmp
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      match_r <= 1'b0;
    end else begin
      match_r <= (q_next_s == cmp);
    end
  end

  assign match = match_r;
`endif

  assign Q          = q_r;
  assign tc         = tc_s;
  assign wrap_pulse = wrap_r;

endmodule

// File: tb/tb_udl_mod_counter.sv
// Scoreboard bench for udl_mod_counter: a wrapping and a saturating instance (BITS=4, MOD=10) share stimulus.
// Define UDL_MATCH_EN to also exercise the cmp/match compare.
module tb_udl_mod_counter;

  localparam int BITS = 4;
  localparam int MOD  = 10;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            enable = 1'b0;
  logic            clr = 1'b0;
  logic            up = 1'b0;
  logic            load = 1'b0;
  logic [BITS-1:0] d = 4'd0;
  logic [BITS-1:0] q0, q1;
  logic            tc0, tc1, w0, w1;
`ifdef UDL_MATCH_EN
  logic [BITS-1:0] cmp = 4'd3;
  logic            m0, m1;
`endif

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [3:0] q0;
    logic       w0;
    logic [3:0] q1;
    logic       w1;
    logic       m0;
    logic       m1;
  } exp_t;

  exp_t sb[$];
  logic [3:0] mq0 = 4'd0;
  logic [3:0] mq1 = 4'd0;

  always #5 clk = ~clk;

  udl_mod_counter #(.BITS(BITS), .MOD(MOD), .SATURATE(0)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clr(clr), .up(up), .load(load), .D(d),
`ifdef UDL_MATCH_EN
    .cmp(cmp), .match(m0),
`endif
    .Q(q0), .tc(tc0), .wrap_pulse(w0)
  );

  udl_mod_counter #(.BITS(BITS), .MOD(MOD), .SATURATE(1)) dut_sat (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clr(clr), .up(up), .load(load), .D(d),
`ifdef UDL_MATCH_EN
    .cmp(cmp), .match(m1),
`endif
    .Q(q1), .tc(tc1), .wrap_pulse(w1)
  );

  function automatic logic [3:0] model_next(input logic [3:0] q, input bit sat,
                                            input logic en, c, u, l, input logic [3:0] dv);
    if (c) return 4'd0;
    if (en && l) return (dv > 4'd9) ? 4'd9 : dv;
    if (!en) return q;
    if (u) return (q == 4'd9) ? (sat ? 4'd9 : 4'd0) : q + 4'd1;
    return (q == 4'd0) ? (sat ? 4'd0 : 4'd9) : q - 4'd1;
  endfunction

  function automatic logic model_tc(input logic [3:0] q, input logic en, c, u, l);
    return en & ~c & ~l & (u ? (q == 4'd9) : (q == 4'd0));
  endfunction

  // Scoreboard monitor: pop the expected state one step after every active edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      tests++;
      if (q0 !== e.q0) begin fails++; $display("FAIL q_wrap: got %0d expected %0d", q0, e.q0); end
      tests++;
      if (w0 !== e.w0) begin fails++; $display("FAIL wrap_pulse_wrap: got %b expected %b (q=%0d)", w0, e.w0, q0); end
      tests++;
      if (q1 !== e.q1) begin fails++; $display("FAIL q_sat: got %0d expected %0d", q1, e.q1); end
      tests++;
      if (w1 !== e.w1) begin fails++; $display("FAIL wrap_pulse_sat: got %b expected %b", w1, e.w1); end
`ifdef UDL_MATCH_EN
      tests++;
      if (m0 !== e.m0) begin fails++; $display("FAIL match_wrap: got %b expected %b (q=%0d)", m0, e.m0, q0); end
      tests++;
      if (m1 !== e.m1) begin fails++; $display("FAIL match_sat: got %b expected %b (q=%0d)", m1, e.m1, q1); end
`endif
    end
  end

  // Drive one cycle from a negedge, check tc, push the expected post-edge state
  task automatic step(input logic en, c, u, l, input logic [3:0] dv);
    exp_t e;
    logic et0, et1;
    logic [3:0] cv;
    enable = en; clr = c; up = u; load = l; d = dv;
    #1;
    et0 = model_tc(mq0, en, c, u, l);
    et1 = model_tc(mq1, en, c, u, l);
    tests++;
    if (tc0 !== et0) begin fails++; $display("FAIL tc_wrap: got %b expected %b (q=%0d)", tc0, et0, q0); end
    tests++;
    if (tc1 !== et1) begin fails++; $display("FAIL tc_sat: got %b expected %b (q=%0d)", tc1, et1, q1); end
`ifdef UDL_MATCH_EN
    cv = cmp;
`else
    cv = 4'd0;
`endif
    e.q0 = model_next(mq0, 1'b0, en, c, u, l, dv);
    e.q1 = model_next(mq1, 1'b1, en, c, u, l, dv);
    e.w0 = et0;
    e.w1 = 1'b0;
    e.m0 = (e.q0 == cv);
    e.m1 = (e.q1 == cv);
    sb.push_back(e);
    mq0 = e.q0;
    mq1 = e.q1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (q0 !== 4'd0 || q1 !== 4'd0) begin fails++; $display("FAIL reset_q: got %0d/%0d expected 0/0", q0, q1); end
    tests++;
    if (w0 !== 1'b0 || w1 !== 1'b0) begin fails++; $display("FAIL reset_wrap: got %b/%b expected 0/0", w0, w1); end
    tests++;
    if (tc0 !== 1'b0) begin fails++; $display("FAIL reset_tc: got %b expected 0", tc0); end
`ifdef UDL_MATCH_EN
    tests++;
    if (m0 !== 1'b0) begin fails++; $display("FAIL reset_match: got %b expected 0", m0); end
`endif
    reset_n = 1'b1;
    mq0 = 4'd0;
    mq1 = 4'd0;
  endtask

  task automatic test_count_up();
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
  endtask

  task automatic test_count_down();
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic test_load();
    step(1'b1, 1'b0, 1'b1, 1'b1, 4'd7);
    step(1'b1, 1'b0, 1'b1, 1'b1, 4'd12);
    step(1'b1, 1'b0, 1'b0, 1'b1, 4'd15);
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'd6);
    step(1'b1, 1'b0, 1'b1, 1'b1, 4'd9);
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'd3);
    step(1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
  endtask

  task automatic test_saturate();
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic test_hold();
    step(1'b1, 1'b0, 1'b1, 1'b1, 4'd4);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 4'($urandom_range(0, 15)));
  endtask

  task automatic test_async_reset();
    step(1'b1, 1'b0, 1'b1, 1'b1, 4'd5);
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if (q0 !== 4'd0 || q1 !== 4'd0) begin fails++; $display("FAIL async_reset_q: got %0d/%0d expected 0/0", q0, q1); end
    reset_n = 1'b1;
    mq0 = 4'd0;
    mq1 = 4'd0;
    @(negedge clk);
    step(1'b1, 1'b0, 1'b1, 1'b1, 4'd9);
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if (w0 !== 1'b0 || q0 !== 4'd0) begin fails++; $display("FAIL async_reset_wrap: got q=%0d w=%b expected q=0 w=0", q0, w0); end
    reset_n = 1'b1;
    mq0 = 4'd0;
    mq1 = 4'd0;
    @(negedge clk);
    step(1'b1, 1'b0, 1'b1, 1'b1, 4'd6);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
  endtask

  task automatic test_match();
`ifdef UDL_MATCH_EN
    cmp = 4'd3;
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    cmp = 4'd0;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
`else
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
`endif
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0), 4'($urandom_range(0, 15)));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    @(negedge clk);
    test_count_up();
    test_count_down();
    test_load();
    test_saturate();
    test_hold();
    test_async_reset();
    test_match();
    test_back_to_back();
    @(negedge clk);
    tests++;
    if (sb.size() != 0) begin fails++; $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
